// File: rtl/tile_plotter_pkg.sv
// Shared types and constants for the tile plotter: FSM state, screen limits,
// colour constants and the on-screen test used for clipping.
package tile_plotter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;

  // Pixels outside the visible 160x120 area are counted but never written.
  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/tile_plotter_if.sv
// Request handshake and VGA adapter pixel bus of the tile plotter.
// master = requester side, slave = plotter side.
interface tile_plotter_if;
  // req_valid/req_ready: a request is accepted on a rising edge where both are
  // high; the plotter latches req_x/req_y/req_color at that edge and ignores
  // the request inputs until it returns to idle.
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  modport master (
    output req_valid, req_x, req_y, req_color,
    input  req_ready, vga_x, vga_y, vga_colour, vga_plot, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color,
    output req_ready, vga_x, vga_y, vga_colour, vga_plot, done
  );
endinterface

// File: rtl/tile_raster_counter.sv
// Raster-order cx/cy counter for one tile (cx fastest) with a last-pixel flag.
// nxt_cx/nxt_cy expose the coordinates that will be current after the next edge.
module tile_raster_counter #(
  parameter int TILE_W = 4,
  parameter int TILE_H = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] nxt_cx,
  output logic [3:0] nxt_cy,
  output logic       last
);

  localparam logic [3:0] CX_LAST = 4'(TILE_W - 1);
  localparam logic [3:0] CY_LAST = 4'(TILE_H - 1);

  logic [3:0] cx;
  logic [3:0] cy;

  always_comb begin
    last   = (cx == CX_LAST) && (cy == CY_LAST);
    nxt_cx = cx;
    nxt_cy = cy;
    if (clear) begin
      nxt_cx = '0;
      nxt_cy = '0;
    end else if (advance) begin
      if (cx == CX_LAST) begin
        nxt_cx = '0;
        nxt_cy = (cy == CY_LAST) ? 4'd0 : cy + 4'd1;
      end else begin
        nxt_cx = cx + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= nxt_cx;
      cy <= nxt_cy;
    end
  end

endmodule

// File: rtl/tile_plotter.sv
// Draws one TILE_W x TILE_H tile per request, one pixel per cycle, to a VGA adapter.
// Optional macro TILE_PLOTTER_BORDER_EN: outline only (interior pixels black).
module tile_plotter
  import tile_plotter_pkg::*;
#(
  parameter int TILE_W = 4,
  parameter int TILE_H = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tile_plotter_if.slave        bus,
  output state_t               state_dbg
);

  localparam logic [3:0] CX_LAST = 4'(TILE_W - 1);
  localparam logic [3:0] CY_LAST = 4'(TILE_H - 1);

  state_t     state;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] base_color;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;
  logic       vga_plot_q;
  logic       done_q;

  logic       accept;
  logic       advance;
  logic       clear;
  logic       last;
  logic [3:0] nxt_cx;
  logic [3:0] nxt_cy;
  logic [7:0] src_x;
  logic [6:0] src_y;
  logic [2:0] src_color;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_plot;

  assign accept  = bus.req_valid && (state == IDLE);
  assign advance = (state == PLOT) && !last;
  assign clear   = accept || ((state == PLOT) && last);

  tile_raster_counter #(
    .TILE_W(TILE_W),
    .TILE_H(TILE_H)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .advance (advance),
    .nxt_cx  (nxt_cx),
    .nxt_cy  (nxt_cy),
    .last    (last)
  );

  // On the accept edge the latched base is not yet valid, so the first pixel
  // is built straight from the request inputs.
  always_comb begin
    src_x      = (state == IDLE) ? bus.req_x     : base_x;
    src_y      = (state == IDLE) ? bus.req_y     : base_y;
    src_color  = (state == IDLE) ? bus.req_color : base_color;
    pix_x      = src_x + {4'b0000, nxt_cx};
    pix_y      = src_y + {3'b000, nxt_cy};
    pix_plot   = on_screen(pix_x, pix_y);
`ifdef TILE_PLOTTER_BORDER_EN
    if ((nxt_cx != 4'd0) && (nxt_cx != CX_LAST) &&
        (nxt_cy != 4'd0) && (nxt_cy != CY_LAST))
      pix_colour = BLACK;
    else
      pix_colour = src_color;
`else
    pix_colour = src_color;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      base_x       <= '0;
      base_y       <= '0;
      base_color   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          vga_plot_q <= 1'b0;
          if (accept) begin
            base_x       <= bus.req_x;
            base_y       <= bus.req_y;
            base_color   <= bus.req_color;
            vga_x_q      <= pix_x;
            vga_y_q      <= pix_y;
            vga_colour_q <= pix_colour;
            vga_plot_q   <= pix_plot;
            state        <= PLOT;
          end
        end
        PLOT: begin
          if (last) begin
            vga_plot_q <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end else begin
            vga_x_q      <= pix_x;
            vga_y_q      <= pix_y;
            vga_colour_q <= pix_colour;
            vga_plot_q   <= pix_plot;
          end
        end
        DONE: begin
          vga_plot_q <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          vga_plot_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.done       = done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_tile_plotter.sv
// Self-checking bench for tile_plotter: table of tiles plus hand sequences for
// back-to-back requests, reset abort and the border option.
module tb_tile_plotter;
  import tile_plotter_pkg::*;

  localparam int TW = 4;
  localparam int TH = 4;
  localparam int NPIX = TW * TH;

  logic   clock;
  logic   reset_n;
  state_t state_dbg;

  tile_plotter_if bus();

  tile_plotter #(.TILE_W(TW), .TILE_H(TH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard entries: {x, y, colour, plot}
  logic [18:0] exp_q[$];

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    int         exp_plots;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] model_pix(input logic [7:0] bx, input logic [6:0] by,
                                            input logic [2:0] c, input int cx, input int cy);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       p;
    x   = bx + 8'(cx);
    y   = by + 7'(cy);
    p   = (x < 8'd160) && (y < 7'd120);
    col = c;
`ifdef TILE_PLOTTER_BORDER_EN
    if (cx > 0 && cx < TW - 1 && cy > 0 && cy < TH - 1) col = 3'b000;
`endif
    return {x, y, col, p};
  endfunction

  task automatic push_tile(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    for (int cy = 0; cy < TH; cy++)
      for (int cx = 0; cx < TW; cx++)
        exp_q.push_back(model_pix(x, y, c, cx, cy));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_req_data();
    bus.req_x     = 8'($urandom_range(0, 255));
    bus.req_y     = 7'($urandom_range(0, 127));
    bus.req_color = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check({name, "_ready_timeout"}, 32'(k < 100), 32'd1);
  endtask

  // Compares NPIX pixel cycles against the scoreboard; returns plot count.
  task automatic compare_pixels(input string name, input bit scramble, output int plots);
    logic [18:0] exp;
    logic [18:0] act;
    plots = 0;
    for (int i = 0; i < NPIX; i++) begin
      act = {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot};
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s_pix%0d", name, i), 32'(act), 32'(exp));
      end
      if (bus.vga_plot === 1'b1) plots++;
      if (scramble) randomize_req_data();
      step();
    end
  endtask

  task automatic run_tile(input string name, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input int exp_plots);
    int plots;
    wait_ready(name);
    bus.req_valid = 1'b1;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_color = c;
    push_tile(x, y, c);
    step();
    bus.req_valid = 1'b0;
    randomize_req_data();
    check({name, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    compare_pixels(name, 1'b1, plots);
    check({name, "_plot_count"}, 32'(plots), 32'(exp_plots));
    check({name, "_done"}, {29'd0, bus.done, bus.vga_plot, bus.req_ready}, 32'b100);
    check({name, "_state_done"}, 32'(state_dbg), 32'(DONE));
    step();
    check({name, "_after"}, {29'd0, bus.done, bus.vga_plot, bus.req_ready}, 32'b001);
  endtask

  initial begin
    int plots;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] bc;

    vecs[0] = '{x: 8'd78,  y: 7'd54,  color: WHITE,  exp_plots: 16};
    vecs[1] = '{x: 8'd158, y: 7'd118, color: WHITE,  exp_plots: 4};
    vecs[2] = '{x: 8'd250, y: 7'd10,  color: 3'b101, exp_plots: 0};
    vecs[3] = '{x: 8'd0,   y: 7'd0,   color: GREEN,  exp_plots: 16};
    vecs[4] = '{x: 8'd156, y: 7'd116, color: 3'b011, exp_plots: 16};
    vecs[5] = '{x: 8'd200, y: 7'd100, color: 3'b001, exp_plots: 0};
    vecs[6] = '{x: 8'd155, y: 7'd117, color: 3'b110, exp_plots: 12};
    vecs[7] = '{x: 8'd159, y: 7'd119, color: 3'b100, exp_plots: 1};

    // reset block
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_color = '0;
    repeat (3) step();
    check("reset_outputs", {bus.vga_x, 1'b0, bus.vga_y, 1'b0, bus.vga_colour,
                            bus.vga_plot, bus.done}, 32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    reset_n = 1'b1;
    step();

    // table-driven tiles
    for (int v = 0; v < 8; v++)
      run_tile($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].color, vecs[v].exp_plots);

    // explicit wrap of x=250: last column of the first row lands on 253
    wait_ready("wrap");
    bus.req_valid = 1'b1; bus.req_x = 8'd250; bus.req_y = 7'd5; bus.req_color = 3'b111;
    push_tile(8'd250, 7'd5, 3'b111);
    step();
    bus.req_valid = 1'b0;
    repeat (3) begin
      void'(exp_q.pop_front());
      step();
    end
    check("wrap_x253", {24'd0, bus.vga_x}, 32'd253);
    check("wrap_plot0", 32'(bus.vga_plot), 32'd0);
    step();
    check("wrap_x_next_row", {24'd0, bus.vga_x}, 32'd250);
    exp_q.delete();
    repeat (NPIX + 2) step();

    // req_valid held high with changing data: tiles start only when ready
    wait_ready("b2b");
    bus.req_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("b2b%0d_ready", t), 32'(bus.req_ready), 32'd1);
      randomize_req_data();
      push_tile(bus.req_x, bus.req_y, bus.req_color);
      step();
      compare_pixels($sformatf("b2b%0d", t), 1'b1, plots);
      check($sformatf("b2b%0d_done", t), {30'd0, bus.done, bus.req_ready}, 32'b10);
      step();
    end
    bus.req_valid = 1'b0;
    step();

    // reset asserted during the 5th PLOT cycle aborts the tile
    wait_ready("rst");
    bus.req_valid = 1'b1; bus.req_x = 8'd78; bus.req_y = 7'd54; bus.req_color = WHITE;
    push_tile(8'd78, 7'd54, WHITE);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_pix%0d", i), 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}),
            32'(exp_q.pop_front()));
      if (i < 4) step();
    end
    reset_n = 1'b0;
    exp_q.delete();
    step();
    check("rst_outputs_zero", {bus.vga_x, 1'b0, bus.vga_y, 1'b0, bus.vga_colour,
                               bus.vga_plot, bus.done}, 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_ready_after", {30'd0, bus.req_ready, bus.vga_plot}, 32'b10);
    step();
    check("rst_no_pixels", {30'd0, bus.vga_plot, bus.done}, 32'b00);

    // border option: perimeter in request colour, interior black when enabled
    wait_ready("border");
    bus.req_valid = 1'b1; bus.req_x = 8'd10; bus.req_y = 7'd20; bus.req_color = GREEN;
    step();
    bus.req_valid = 1'b0;
    begin
      int n_green;
      int n_black;
      n_green = 0;
      n_black = 0;
      for (int i = 0; i < NPIX; i++) begin
        if (bus.vga_colour === GREEN) n_green++;
        if (bus.vga_colour === BLACK) n_black++;
        step();
      end
`ifdef TILE_PLOTTER_BORDER_EN
      check("border_green", 32'(n_green), 32'd12);
      check("border_black", 32'(n_black), 32'd4);
`else
      check("solid_green", 32'(n_green), 32'd16);
      check("solid_black", 32'(n_black), 32'd0);
`endif
    end
    check("border_done", 32'(bus.done), 32'd1);
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
